// File: rtl/spi_xfer_sched.sv
`default_nettype none
// ============================================================================
// spi_xfer_sched : round-robin scheduler of two requesters onto one SPI engine
// Revision       : 1.0 - initial release
// ============================================================================
module spi_xfer_sched #(
  parameter int CS_SETUP = 2,
  parameter int CS_GAP   = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_txdata,
  input  logic       req0_last,
  output logic       req0_ready,
  output logic       rsp0_valid,
  output logic [7:0] rsp0_data,
  input  logic       req1_valid,
  input  logic [7:0] req1_txdata,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       rsp1_valid,
  output logic [7:0] rsp1_data,
  output logic [1:0] grant,
  output logic [1:0] ss_n,
  output logic       timeout,
  output logic [7:0] eng_txdata,
  output logic       eng_txstart,
  input  logic       eng_busy,
  input  logic [7:0] eng_rxdata
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETUP     = 3'd1,
    WAIT_BYTE = 3'd2,
    START     = 3'd3,
    XFER      = 3'd4,
    GAP       = 3'd5
  } state_t;

  localparam logic [7:0] SETUP_LD = 8'(CS_SETUP);
  localparam logic [7:0] GAP_LD   = 8'(CS_GAP);
  localparam logic [8:0] TMO      = 9'(TIMEOUT);

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [7:0] idle_cnt, idle_n;
  logic       rr_last, rr_n;
  logic       last_q, last_n;
  logic [1:0] grant_n, ss_n_n, ready_n, rsp_valid_n;
  logic [7:0] rsp0_data_n, rsp1_data_n, txdata_n;
  logic       txstart_n, timeout_n;

  logic       owner, own_valid, own_last, own_ready, fire, win;
  logic [7:0] own_data;

  assign owner     = grant[1];
  assign own_valid = owner ? req1_valid  : req0_valid;
  assign own_data  = owner ? req1_txdata : req0_txdata;
  assign own_last  = owner ? req1_last   : req0_last;
  assign own_ready = owner ? req1_ready  : req0_ready;
  assign fire      = (state == WAIT_BYTE) && own_valid && own_ready;
  // On a tie the requester that did not win last time takes the bus.
  assign win       = (req0_valid && req1_valid) ? ~rr_last : req1_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      idle_cnt    <= 8'd0;
      rr_last     <= 1'b1;
      last_q      <= 1'b0;
      grant       <= 2'b00;
      ss_n        <= 2'b11;
      req0_ready  <= 1'b0;
      req1_ready  <= 1'b0;
      rsp0_valid  <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp0_data   <= 8'd0;
      rsp1_data   <= 8'd0;
      eng_txdata  <= 8'd0;
      eng_txstart <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idle_cnt    <= idle_n;
      rr_last     <= rr_n;
      last_q      <= last_n;
      grant       <= grant_n;
      ss_n        <= ss_n_n;
      req0_ready  <= ready_n[0];
      req1_ready  <= ready_n[1];
      rsp0_valid  <= rsp_valid_n[0];
      rsp1_valid  <= rsp_valid_n[1];
      rsp0_data   <= rsp0_data_n;
      rsp1_data   <= rsp1_data_n;
      eng_txdata  <= txdata_n;
      eng_txstart <= txstart_n;
      timeout     <= timeout_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    idle_n      = idle_cnt;
    rr_n        = rr_last;
    last_n      = last_q;
    grant_n     = grant;
    ss_n_n      = ss_n;
    ready_n     = 2'b00;
    rsp_valid_n = 2'b00;
    rsp0_data_n = rsp0_data;
    rsp1_data_n = rsp1_data;
    txdata_n    = eng_txdata;
    txstart_n   = 1'b0;
    timeout_n   = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          grant_n = win ? 2'b10 : 2'b01;
          ss_n_n  = win ? 2'b01 : 2'b10;
          rr_n    = win;
          cnt_n   = SETUP_LD;
          state_n = SETUP;
        end
      end
      SETUP: begin
        if (cnt <= 8'd1) begin
          idle_n  = 8'd0;
          state_n = WAIT_BYTE;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      WAIT_BYTE: begin
        if (fire) begin
          txdata_n  = own_data;
          last_n    = own_last;
          txstart_n = 1'b1;
          state_n   = START;
        end else if ((TMO != 9'd0) && (({1'b0, idle_cnt} + 9'd1) == TMO)) begin
          timeout_n = 1'b1;
          grant_n   = 2'b00;
          ss_n_n    = 2'b11;
          cnt_n     = GAP_LD;
          state_n   = GAP;
        end else begin
          // Ready is registered, so it trails WAIT_BYTE entry by one cycle.
          idle_n  = idle_cnt + 8'd1;
          ready_n = grant;
        end
      end
      START: begin
        state_n = XFER;
      end
      XFER: begin
        if (!eng_busy) begin
          if (owner) begin
            rsp1_data_n    = eng_rxdata;
            rsp_valid_n[1] = 1'b1;
          end else begin
            rsp0_data_n    = eng_rxdata;
            rsp_valid_n[0] = 1'b1;
          end
          if (last_q) begin
            grant_n = 2'b00;
            ss_n_n  = 2'b11;
            cnt_n   = GAP_LD;
            state_n = GAP;
          end else begin
            idle_n  = 8'd0;
            state_n = WAIT_BYTE;
          end
        end
      end
      GAP: begin
        if (cnt <= 8'd1) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_xfer_sched.sv
`default_nettype none
// ============================================================================
// tb_spi_xfer_sched : randomized scoreboard bench with a loopback SPI engine
// Revision          : 1.0 - initial release
// ============================================================================
module tb_spi_xfer_sched;

  localparam int CS_SETUP = 2;
  localparam int CS_GAP   = 2;
  localparam int TIMEOUT  = 10;
  localparam int BUDGET   = 2000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_v [2];
  logic [7:0] req_d [2];
  logic       req_l [2];
  logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid, timeout, eng_txstart;
  logic [7:0] rsp0_data, rsp1_data, eng_txdata;
  logic [1:0] grant, ss_n;
  logic       eng_busy;
  logic [7:0] eng_rxdata;
  logic [4:0] eng_cnt;
  logic [7:0] eng_sh;

  int         checks = 0;
  int         failures = 0;
  logic [8:0] exp_rsp [$];
  logic [7:0] exp_tx [$];
  logic       win_log [$];
  int         grant_rises = 0;
  int         txstarts = 0;
  int         rsps = 0;
  logic       tmo_ok = 1'b0;
  logic       done4 = 1'b0;

  always #5 clk = ~clk;

  spi_xfer_sched #(.CS_SETUP(CS_SETUP), .CS_GAP(CS_GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req_v[0]), .req0_txdata(req_d[0]), .req0_last(req_l[0]), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .req1_valid(req_v[1]), .req1_txdata(req_d[1]), .req1_last(req_l[1]), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .grant(grant), .ss_n(ss_n), .timeout(timeout),
    .eng_txdata(eng_txdata), .eng_txstart(eng_txstart), .eng_busy(eng_busy), .eng_rxdata(eng_rxdata)
  );

  // Loopback engine: busy for 16 cycles after the start pulse; rxdata updates as busy falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_busy <= 1'b0; eng_cnt <= 5'd0; eng_sh <= 8'd0; eng_rxdata <= 8'd0;
    end else if (eng_txstart && !eng_busy) begin
      eng_busy <= 1'b1; eng_cnt <= 5'd16; eng_sh <= eng_txdata;
    end else if (eng_busy) begin
      if (eng_cnt == 5'd1) begin
        eng_busy <= 1'b0; eng_rxdata <= eng_sh;
      end
      eng_cnt <= eng_cnt - 5'd1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic rdy(input int id);
    return (id == 0) ? req0_ready : req1_ready;
  endfunction

  task automatic send(input int id, input logic [7:0] d, input logic l);
    int n = 0;
    req_v[id] = 1'b1; req_d[id] = d; req_l[id] = l;
    do begin @(negedge clk); n++; end while (!rdy(id) && n < BUDGET);
    chk("send_ready_seen", {31'd0, rdy(id)}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic settle();
    int n = 0;
    do begin @(negedge clk); n++; end
    while ((grant != 2'b00 || exp_rsp.size() != 0) && n < BUDGET);
    chk("settle", {31'd0, (grant == 2'b00) && (exp_rsp.size() == 0)}, 32'd1);
    repeat (CS_GAP + 2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  // Monitor and reference model: arbitration, CS timing, and a byte scoreboard.
  logic       rr_model = 1'b1;
  logic       pv0 = 1'b0, pv1 = 1'b0, released = 1'b0, held = 1'b0, exp_win;
  logic [1:0] prev_grant = 2'b00;
  int         hi_cnt = 0, since_grant = -1;
  logic [8:0] er;
  logic [7:0] et;

  always @(negedge clk) begin
    if (rst) begin
      rr_model = 1'b1; released = 1'b0; since_grant = -1; hi_cnt = 0;
      exp_rsp.delete(); exp_tx.delete();
    end else begin
      chk("ss_n_vs_grant", {30'd0, ss_n}, {30'd0, ~grant});
      chk("grant_onehot", {31'd0, grant == 2'b11}, 32'd0);
      chk("ready0_owner_only", {31'd0, req0_ready && !grant[0]}, 32'd0);
      chk("ready1_owner_only", {31'd0, req1_ready && !grant[1]}, 32'd0);
      if (timeout) chk("timeout_expected", {31'd0, tmo_ok}, 32'd1);
      if (grant != 2'b00 && prev_grant == 2'b00) begin
        grant_rises++;
        exp_win = (pv0 && pv1) ? !rr_model : pv1;
        chk("grant_winner", {30'd0, grant}, exp_win ? 32'd2 : 32'd1);
        rr_model = exp_win;
        win_log.push_back(grant[1]);
        if (released) begin
          if (held) chk("cs_gap_exact", hi_cnt, CS_GAP + 1);
          else      chk("cs_gap_min", {31'd0, hi_cnt >= CS_GAP + 1}, 32'd1);
        end
        released = 1'b0;
        since_grant = 0;
      end
      if (grant == 2'b00 && prev_grant != 2'b00) begin
        released = 1'b1; hi_cnt = 0; held = 1'b1; since_grant = -1;
      end
      if (grant == 2'b00 && released) begin
        hi_cnt++;
        held = held && (req_v[0] || req_v[1]);
      end
      if (since_grant >= 0) begin
        if (since_grant < CS_SETUP) chk("setup_no_ready", {31'd0, req0_ready || req1_ready}, 32'd0);
        if (eng_txstart) begin
          chk("setup_length", {31'd0, since_grant >= CS_SETUP}, 32'd1);
          since_grant = -1;
        end else begin
          since_grant++;
        end
      end
      if (eng_txstart) begin
        txstarts++;
        chk("txstart_engine_idle", {31'd0, eng_busy}, 32'd0);
        chk("txstart_expected", {31'd0, exp_tx.size() != 0}, 32'd1);
        if (exp_tx.size() != 0) begin
          et = exp_tx.pop_front();
          chk("eng_txdata", {24'd0, eng_txdata}, {24'd0, et});
        end
      end
      if (rsp0_valid || rsp1_valid) begin
        rsps++;
        chk("rsp_single", {31'd0, rsp0_valid && rsp1_valid}, 32'd0);
        chk("rsp_expected", {31'd0, exp_rsp.size() != 0}, 32'd1);
        if (exp_rsp.size() != 0) begin
          er = exp_rsp.pop_front();
          chk("rsp_id", {31'd0, rsp1_valid}, {31'd0, er[8]});
          chk("rsp_data", {24'd0, er[8] ? rsp1_data : rsp0_data}, {24'd0, er[7:0]});
        end
      end
      if (req_v[0] && req0_ready) begin
        exp_tx.push_back(req_d[0]); exp_rsp.push_back({1'b0, req_d[0]});
      end
      if (req_v[1] && req1_ready) begin
        exp_tx.push_back(req_d[1]); exp_rsp.push_back({1'b1, req_d[1]});
      end
    end
    pv0 = req_v[0]; pv1 = req_v[1]; prev_grant = grant;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  int g0, t0, r0, n6;
  initial begin
    req_v[0] = 1'b0; req_v[1] = 1'b0; req_d[0] = 8'd0; req_d[1] = 8'd0; req_l[0] = 1'b0; req_l[1] = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_ss_n", {30'd0, ss_n}, 32'd3);
    chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("rst_rsp_data", {16'd0, rsp1_data, rsp0_data}, 32'd0);
    chk("rst_eng", {23'd0, eng_txstart, eng_txdata}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Single byte from requester 0
    send(0, 8'hA5, 1'b1); req_v[0] = 1'b0;
    settle();

    // Three-byte burst on requester 1 under one CS assertion
    g0 = grant_rises; t0 = txstarts; r0 = rsps;
    send(1, 8'h01, 1'b0); send(1, 8'h02, 1'b0); send(1, 8'h03, 1'b1); req_v[1] = 1'b0;
    settle();
    chk("burst_grants", grant_rises - g0, 32'd1);
    chk("burst_txstarts", txstarts - t0, 32'd3);
    chk("burst_rsps", rsps - r0, 32'd3);

    // Simultaneous requests from reset, then again: strict alternation
    rst = 1'b1; win_log.delete();
    fork
      begin repeat (2) @(posedge clk); #1 rst = 1'b0; end
      begin send(0, 8'($urandom), 1'b1); req_v[0] = 1'b0; end
      begin send(1, 8'($urandom), 1'b1); req_v[1] = 1'b0; end
    join
    settle();
    fork
      begin send(0, 8'($urandom), 1'b1); req_v[0] = 1'b0; end
      begin send(1, 8'($urandom), 1'b1); req_v[1] = 1'b0; end
    join
    settle();
    chk("rr_count", win_log.size(), 32'd4);
    if (win_log.size() == 4)
      for (int k = 0; k < 4; k++) chk("rr_order", {31'd0, win_log[k]}, k % 2);

    // Non-owner noise during a requester 0 burst
    done4 = 1'b0;
    fork
      begin
        for (int k = 0; k < 4; k++) send(0, 8'($urandom), k == 3);
        req_v[0] = 1'b0; done4 = 1'b1;
      end
      begin
        while (!done4) begin
          @(posedge clk); #1;
          if (grant == 2'b01 && !done4) begin
            req_v[1] = 1'($urandom_range(0, 1)); req_d[1] = 8'($urandom);
          end else begin
            req_v[1] = 1'b0;
          end
        end
        req_v[1] = 1'b0;
      end
    join
    settle();

    // Stalled owner is released by the timeout; pending requester 1 follows
    tmo_ok = 1'b1;
    fork
      begin send(0, 8'($urandom), 1'b0); req_v[0] = 1'b0; end
      begin repeat (5) @(posedge clk); #1; send(1, 8'($urandom), 1'b1); req_v[1] = 1'b0; end
      begin : measure
        int n5;
        n5 = 0;
        do begin @(negedge clk); n5++; end while (!rsp0_valid && n5 < BUDGET);
        chk("t5_rsp0_seen", {31'd0, rsp0_valid}, 32'd1);
        n5 = 0;
        do begin @(negedge clk); n5++; end while (!timeout && n5 < 100);
        chk("timeout_latency", n5, TIMEOUT);
        chk("timeout_ss_n", {30'd0, ss_n}, 32'd3);
        chk("timeout_grant", {30'd0, grant}, 32'd0);
      end
    join
    settle();
    tmo_ok = 1'b0;

    // Reset during a transfer
    send(0, 8'($urandom), 1'b1); req_v[0] = 1'b0;
    n6 = 0;
    do begin @(negedge clk); n6++; end while (!eng_busy && n6 < 200);
    chk("t6_in_xfer", {31'd0, eng_busy}, 32'd1);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_ss_n", {30'd0, ss_n}, 32'd3);
    chk("midrst_grant", {30'd0, grant}, 32'd0);
    chk("midrst_txstart_rsp", {30'd0, eng_txstart, rsp0_valid}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (30) @(posedge clk); #1;
    send(1, 8'($urandom), 1'b1); req_v[1] = 1'b0;
    settle();

    // Randomized contention
    for (int round = 0; round < 4; round++) begin
      fork
        begin
          int len0;
          for (int b = 0; b < 5; b++) begin
            repeat ($urandom_range(1, 13)) @(posedge clk); #1;
            len0 = $urandom_range(1, 3);
            for (int k = 0; k < len0; k++) send(0, 8'($urandom), k == len0 - 1);
            req_v[0] = 1'b0;
          end
        end
        begin
          int len1;
          for (int b = 0; b < 5; b++) begin
            repeat ($urandom_range(1, 13)) @(posedge clk); #1;
            len1 = $urandom_range(1, 3);
            for (int k = 0; k < len1; k++) send(1, 8'($urandom), k == len1 - 1);
            req_v[1] = 1'b0;
          end
        end
      join
      settle();
    end

    chk("rsp_queue_drained", exp_rsp.size(), 32'd0);
    chk("tx_queue_drained", exp_tx.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
